// File: rtl/bk_addseq_if.sv
// Bundle between the ALU op-decode, the byte-serial add/sub sequencer and the shared 8-bit adder slice.
// The slave modport is the sequencer's view; the master modport is the decode/adder side.
interface bk_addseq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         ready;
  logic         sub;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         Cout;
  logic [7:0]   addA;
  logic [7:0]   addB;
  logic         addCin;
  logic [7:0]   addSum;
  logic         addCout;

  modport slave (
    input  start, sub, opA, opB, addSum, addCout,
    output ready, busy, done, Result, Cout, addA, addB, addCin
  );

  modport master (
    output start, sub, opA, opB, addSum, addCout,
    input  ready, busy, done, Result, Cout, addA, addB, addCin
  );
endinterface

// File: rtl/bk_addseq_ctrl.sv
// Byte-serial N-byte add/subtract sequencer around one shared 8-bit adder slice, LSB first.
// Optional signed-overflow output Ovf is built when BKSEQ_OVF_FLAG_EN is defined.
module bk_addseq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef BKSEQ_OVF_FLAG_EN
  output logic Ovf,
`endif
  bk_addseq_if.slave bus
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = (W > 8) ? $clog2(W) : 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  beff_q;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          accept;
  logic          last_byte;
  logic [SW-1:0] lsb;

  assign accept    = (state == IDLE) && bus.start;
  assign last_byte = (state == RUN) && (idx == LAST);

  always_comb begin
    lsb = SW'(idx) << 3;
  end

  // Operand capture: subtract is folded into the operand as ~B with carry-in 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= bus.opA;
      beff_q <= bus.sub ? ~bus.opB : bus.opB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            carry <= bus.sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result_q[lsb +: 8] <= bus.addSum;
          carry              <= bus.addCout;
          if (idx == LAST) begin
            cout_q <= bus.addCout;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BKSEQ_OVF_FLAG_EN
  logic ovf_q;

  // Operands share a sign but the top result bit differs: two's-complement overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last_byte) begin
      ovf_q <= (a_q[W-1] == beff_q[W-1]) && (bus.addSum[7] != a_q[W-1]);
    end
  end

  assign Ovf = ovf_q;
`endif

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state == RUN) || (state == DONE);
  assign bus.done   = (state == DONE);
  assign bus.Result = result_q;
  assign bus.Cout   = cout_q;

  // Adder operands are forced to zero outside RUN so the shared slice sees no stale bytes.
  always_comb begin
    bus.addA   = 8'h00;
    bus.addB   = 8'h00;
    bus.addCin = 1'b0;
    if (state == RUN) begin
      bus.addA   = a_q[lsb +: 8];
      bus.addB   = beff_q[lsb +: 8];
      bus.addCin = carry;
    end
  end

endmodule

// File: tb/tb_bk_addseq_ctrl.sv
// Directed self-checking bench: a 4-byte and a 1-byte sequencer, each with a behavioural 8-bit adder.
// Define BKSEQ_OVF_FLAG_EN for both bench and RTL to exercise the overflow flag.
module tb_bk_addseq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bk_addseq_if #(.NBYTES(4)) b4 ();
  bk_addseq_if #(.NBYTES(1)) b1 ();

`ifdef BKSEQ_OVF_FLAG_EN
  logic ovf4;
  logic ovf1;
`endif

  bk_addseq_ctrl #(.NBYTES(4)) dut4 (
    .clk (clk),
    .rst (rst),
`ifdef BKSEQ_OVF_FLAG_EN
    .Ovf (ovf4),
`endif
    .bus (b4.slave)
  );

  bk_addseq_ctrl #(.NBYTES(1)) dut1 (
    .clk (clk),
    .rst (rst),
`ifdef BKSEQ_OVF_FLAG_EN
    .Ovf (ovf1),
`endif
    .bus (b1.slave)
  );

  assign {b4.addCout, b4.addSum} = {1'b0, b4.addA} + {1'b0, b4.addB} + {8'h00, b4.addCin};
  assign {b1.addCout, b1.addSum} = {1'b0, b1.addA} + {1'b0, b1.addB} + {8'h00, b1.addCin};

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  cap_a [4];
  logic [7:0]  cap_b [4];
  logic        cap_c [4];
  logic [31:0] res;
  logic        cout;
  logic        done_early;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full 4-byte operation; glitch_at >= 0 pulses start with junk operands in that RUN cycle.
  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic s, input int glitch_at);
    int guard;
    guard = 0;
    while (!b4.ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_start", {63'd0, b4.ready}, 64'd1);
    b4.opA   = a;
    b4.opB   = b;
    b4.sub   = s;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start   = 1'b0;
    b4.opA     = 32'h0;
    b4.opB     = 32'h0;
    b4.sub     = 1'b0;
    done_early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap_a[i] = b4.addA;
      cap_b[i] = b4.addB;
      cap_c[i] = b4.addCin;
      done_early |= b4.done;
      if (i == glitch_at) begin
        b4.start = 1'b1;
        b4.opA   = 32'hAAAAAAAA;
        b4.opB   = 32'h55555555;
        b4.sub   = 1'b1;
      end else begin
        b4.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    b4.start = 1'b0;
    chk("no_done_during_run", {63'd0, done_early}, 64'd0);
    chk("done_pulse", {63'd0, b4.done}, 64'd1);
    chk("busy_in_done", {63'd0, b4.busy}, 64'd1);
    res  = b4.Result;
    cout = b4.Cout;
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, b4.done}, 64'd0);
    chk("ready_after_done", {63'd0, b4.ready}, 64'd1);
    chk("result_hold", {32'd0, b4.Result}, {32'd0, res});
  endtask

  initial begin
    b4.start = 1'b0; b4.sub = 1'b0; b4.opA = '0; b4.opB = '0;
    b1.start = 1'b0; b1.sub = 1'b0; b1.opA = '0; b1.opB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, b4.ready}, 64'd1);
    chk("rst_busy", {63'd0, b4.busy}, 64'd0);
    chk("rst_done", {63'd0, b4.done}, 64'd0);
    chk("rst_result", {32'd0, b4.Result}, 64'd0);
    chk("rst_cout", {63'd0, b4.Cout}, 64'd0);
    chk("rst_addA", {56'd0, b4.addA}, 64'd0);
    chk("rst_addB", {56'd0, b4.addB}, 64'd0);
    chk("rst_addCin", {63'd0, b4.addCin}, 64'd0);
`ifdef BKSEQ_OVF_FLAG_EN
    chk("rst_ovf", {63'd0, ovf4}, 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    op4(32'hFFFFFFFF, 32'h00000001, 1'b0, -1);
    chk("ff_plus1_result", {32'd0, res}, 64'h0);
    chk("ff_plus1_cout", {63'd0, cout}, 64'd1);
    chk("ff_plus1_cin_seq", {60'd0, cap_c[3], cap_c[2], cap_c[1], cap_c[0]}, 64'hE);

    op4(32'h12345678, 32'h11111111, 1'b0, -1);
    chk("add_result", {32'd0, res}, 64'h23456789);
    chk("add_cout", {63'd0, cout}, 64'd0);
    chk("add_addA_seq", {32'd0, cap_a[3], cap_a[2], cap_a[1], cap_a[0]}, 64'h12345678);
    chk("add_addB_seq", {32'd0, cap_b[3], cap_b[2], cap_b[1], cap_b[0]}, 64'h11111111);
    chk("add_cin_seq", {60'd0, cap_c[3], cap_c[2], cap_c[1], cap_c[0]}, 64'h0);

    op4(32'h00000000, 32'h00000001, 1'b1, -1);
    chk("sub_borrow_result", {32'd0, res}, 64'hFFFFFFFF);
    chk("sub_borrow_cout", {63'd0, cout}, 64'd0);
    chk("sub_byte0_cin", {63'd0, cap_c[0]}, 64'd1);
    chk("sub_byte0_addB", {56'd0, cap_b[0]}, 64'hFE);
    chk("sub_byte1_addB", {56'd0, cap_b[1]}, 64'hFF);

    op4(32'h00000005, 32'h00000003, 1'b1, -1);
    chk("sub_noborrow_result", {32'd0, res}, 64'h2);
    chk("sub_noborrow_cout", {63'd0, cout}, 64'd1);

    op4(32'h00000010, 32'h00000020, 1'b0, 1);
    chk("ignored_start_result", {32'd0, res}, 64'h30);
    chk("ignored_start_cout", {63'd0, cout}, 64'd0);

`ifdef BKSEQ_OVF_FLAG_EN
    op4(32'h7FFFFFFF, 32'h00000001, 1'b0, -1);
    chk("ovf_add_result", {32'd0, res}, 64'h80000000);
    chk("ovf_add_cout", {63'd0, cout}, 64'd0);
    chk("ovf_add_flag", {63'd0, ovf4}, 64'd1);
    op4(32'h80000000, 32'h00000001, 1'b1, -1);
    chk("ovf_sub_result", {32'd0, res}, 64'h7FFFFFFF);
    chk("ovf_sub_cout", {63'd0, cout}, 64'd1);
    chk("ovf_sub_flag", {63'd0, ovf4}, 64'd1);
    op4(32'h12345678, 32'h11111111, 1'b0, -1);
    chk("ovf_clear_flag", {63'd0, ovf4}, 64'd0);
`endif

    // Abort: reset sampled on the edge that ends the second RUN cycle.
    b4.opA = 32'h01010101; b4.opB = 32'h02020202; b4.sub = 1'b0; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", {63'd0, b4.busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", {63'd0, b4.ready}, 64'd1);
    chk("abort_result", {32'd0, b4.Result}, 64'h0);
    chk("abort_done", {63'd0, b4.done}, 64'd0);
    chk("abort_addA", {56'd0, b4.addA}, 64'h0);
    done_early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      done_early |= b4.done;
    end
    chk("abort_no_done_later", {63'd0, done_early}, 64'd0);

    b1.opA = 8'hC8; b1.opB = 8'h64; b1.sub = 1'b0; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    chk("n1_addA", {56'd0, b1.addA}, 64'hC8);
    chk("n1_addB", {56'd0, b1.addB}, 64'h64);
    chk("n1_addCin", {63'd0, b1.addCin}, 64'd0);
    chk("n1_done_not_yet", {63'd0, b1.done}, 64'd0);
    @(posedge clk); #1;
    chk("n1_done", {63'd0, b1.done}, 64'd1);
    chk("n1_result", {56'd0, b1.Result}, 64'h2C);
    chk("n1_cout", {63'd0, b1.Cout}, 64'd1);
`ifdef BKSEQ_OVF_FLAG_EN
    chk("n1_ovf", {63'd0, ovf1}, 64'd0);
`endif
    @(posedge clk); #1;
    chk("n1_done_cleared", {63'd0, b1.done}, 64'd0);
    chk("n1_ready", {63'd0, b1.ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
